if_prefetch_unit: RTL

Parametrised instruction-fetch stage with a prefetch queue. It holds the fetch PC, reads a synchronous instruction ROM, and buffers fetched words tagged with their PC in a small FIFO. Decode consumes the FIFO through a valid/ready handshake, and the execute stage redirects fetch with an absolute target that flushes all prefetched work. It replaces the single-register fetch stage between instruction memory and decode.

---
 rtl/if_prefetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, reads a synchronous ROM and
// queues {instr, pc} pairs for decode; a redirect flushes all prefetched work.
module if_prefetch_unit #(
  parameter int              PC_W       = 12,
  parameter int              IMEM_AW    = 10,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter string           INIT_FILE  = "assembly_rom.data",
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            fetch_en,
  input  logic                            redirect,
  input  logic [PC_W-1:0]                 redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_instr,
  output logic [PC_W-1:0]                 out_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int ROM_DEPTH = 1 << IMEM_AW;

  logic [DATA_W-1:0] rom [ROM_DEPTH];

  logic [PC_W-1:0]   fpc;
  logic [DATA_W-1:0] rom_q;
  logic [PC_W-1:0]   q_pc;
  logic              inflight;

  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_mem    [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic [CW:0]       credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_pc_bits;

  // The in-flight word holds a reserved slot, so a push never finds the queue full.
  assign credit    = {1'b0, count} + (CW+1)'(inflight);
  assign issue     = fetch_en && !redirect && (credit < (CW+1)'(FIFO_DEPTH));
  assign push      = inflight && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
  assign level     = count;

  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fpc      <= {redirect_pc[PC_W-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) fpc    <= fpc + PC_W'(4);
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: every read of it is qualified by inflight or count.
  always_ff @(posedge clk) begin
    if (issue) begin
      rom_q <= rom[fpc[IMEM_AW+1:2]];
      q_pc  <= fpc;
    end
    if (push) begin
      instr_mem[wr_ptr] <= rom_q;
      pc_mem[wr_ptr]    <= q_pc;
    end
  end

endmodule
